neopixel_status_arbiter: RTL

- Shares the single on-board NeoPixel driver between up to NUM_REQ status sources, such as the pin-test FSM, the motor fault monitor and the bus-activity indicator.
- Arbitrates colour-change requests round-robin, latches the winning colour and issues a one-cycle send strobe to the neopixel driver.
- Enforces frame spacing and a minimum display time so the WS2812 protocol is never violated and short status flashes stay visible.
- Sits between the status sources and the neopixel instance in the top level.

---
 rtl/neopixel_status_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/neopixel_status_arbiter.sv
// Round-robin arbiter that shares one NeoPixel driver between several status sources,
// enforcing WS2812 frame spacing and a minimum display time per colour.
module neopixel_status_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned CLK_FREQ        = 16_000_000,
    parameter int unsigned FRAME_US        = 80,
    parameter int unsigned MIN_SHOW_CYCLES = 1_600_000
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [24*NUM_REQ-1:0]  color_in,
    output logic [NUM_REQ-1:0]     ack,
    output logic [23:0]            color_out,
    output logic                   send_to_neopixels,
    output logic                   busy,
    output logic [2:0]             owner
);

    localparam int unsigned FRAME_CYCLES = CLK_FREQ / 1_000_000 * FRAME_US;
    localparam int unsigned FRAME_W      = $clog2(FRAME_CYCLES) + 1;
    localparam int unsigned HOLD_W       = $clog2(MIN_SHOW_CYCLES) + 1;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StArb,
        StSend,
        StFrameWait,
        StHold
    } state_t;

    state_t               r_state,      w_state_nxt;
    logic [2:0]           r_last,       w_last_nxt;
    logic [2:0]           r_owner,      w_owner_nxt;
    logic [23:0]          r_color_lat,  w_color_lat_nxt;
    logic [23:0]          r_color_out,  w_color_out_nxt;
    logic                 r_send,       w_send_nxt;
    logic [NUM_REQ-1:0]   r_ack,        w_ack_nxt;
    logic [FRAME_W-1:0]   r_frame_cnt,  w_frame_cnt_nxt;
    logic [HOLD_W-1:0]    r_hold_cnt,   w_hold_cnt_nxt;
    logic                 r_from_init,  w_from_init_nxt;

    logic [7:0]           w_req_pad;
    logic [2:0]           w_idx;
    logic [2:0]           w_win;
    logic                 w_found;
    logic [23:0]          w_win_color;

    // Search starts one past the last winner so a held request cannot starve the others.
    always_comb begin
        w_req_pad = 8'(req);
        w_found   = 1'b0;
        w_win     = '0;
        w_idx     = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            w_idx = 3'((int'(r_last) + i) % int'(NUM_REQ));
            if (!w_found && w_req_pad[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        w_win_color = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_win == 3'(i)) begin
                w_win_color = color_in[24*i +: 24];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_owner_nxt     = r_owner;
        w_color_lat_nxt = r_color_lat;
        w_color_out_nxt = r_color_out;
        w_send_nxt      = 1'b0;
        w_ack_nxt       = '0;
        w_frame_cnt_nxt = r_frame_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_from_init_nxt = r_from_init;
        case (r_state)
            StInit: begin
                w_color_out_nxt = '0;
                w_send_nxt      = 1'b1;
                w_frame_cnt_nxt = FRAME_W'(FRAME_CYCLES - 1);
                w_from_init_nxt = 1'b1;
                w_state_nxt     = StFrameWait;
            end
            StIdle: begin
                if (|req) begin
                    w_state_nxt = StArb;
                end
            end
            StArb: begin
                if (w_found) begin
                    w_ack_nxt       = NUM_REQ'(8'd1 << w_win);
                    w_color_lat_nxt = w_win_color;
                    w_last_nxt      = w_win;
                    w_owner_nxt     = w_win;
                    // Re-sending an identical colour would only waste a display slot.
                    w_state_nxt     = (w_win_color == r_color_out) ? StIdle : StSend;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StSend: begin
                w_color_out_nxt = r_color_lat;
                w_send_nxt      = 1'b1;
                w_frame_cnt_nxt = FRAME_W'(FRAME_CYCLES - 1);
                w_from_init_nxt = 1'b0;
                w_state_nxt     = StFrameWait;
            end
            StFrameWait: begin
                if (r_frame_cnt == '0) begin
                    if (r_from_init) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_hold_cnt_nxt = HOLD_W'(MIN_SHOW_CYCLES - 1);
                        w_state_nxt    = StHold;
                    end
                end else begin
                    w_frame_cnt_nxt = r_frame_cnt - FRAME_W'(1);
                end
            end
            StHold: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
                end
            end
            default: w_state_nxt = StInit;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StInit;
            r_last      <= 3'(NUM_REQ - 1);
            r_owner     <= '0;
            r_color_lat <= '0;
            r_color_out <= '0;
            r_send      <= 1'b0;
            r_ack       <= '0;
            r_frame_cnt <= '0;
            r_hold_cnt  <= '0;
            r_from_init <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_owner     <= w_owner_nxt;
            r_color_lat <= w_color_lat_nxt;
            r_color_out <= w_color_out_nxt;
            r_send      <= w_send_nxt;
            r_ack       <= w_ack_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_from_init <= w_from_init_nxt;
        end
    end

    assign ack               = r_ack;
    assign color_out         = r_color_out;
    assign send_to_neopixels = r_send;
    assign owner             = r_owner;
    assign busy              = (r_state != StIdle);

endmodule
